// File: rtl/enigma_pkg.sv
// Shared definitions for the rotor stepping block: letter width, alphabet
// size, default turnover notches and the controller state encoding.
package enigma_pkg;

    localparam int LETTER_W        = 5;
    localparam int ALPHA           = 26;
    localparam int NOTCH_R_DEFAULT = 21;
    localparam int NOTCH_M_DEFAULT = 4;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Largest legal position/letter for a given alphabet size.
    function automatic letter_t last_letter(input int alpha);
        return letter_t'(alpha - 1);
    endfunction

endpackage

// File: rtl/rotor_counter.sv
// Single rotor position: a mod-ALPHA counter that advances by one on inc and
// flags when it sits on its turnover notch.
module rotor_counter
    import enigma_pkg::*;
#(
    parameter int ALPHA = enigma_pkg::ALPHA,
    parameter int NOTCH = 0
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    inc,
    output letter_t pos,
    output logic    at_notch
);

    localparam letter_t LAST      = last_letter(ALPHA);
    localparam letter_t NOTCH_POS = letter_t'(NOTCH);

    // Position register: synchronous clear, wrap from the last position to 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the pre-step notch
    // decisions in the controller hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos <= '0;
        end else if (inc) begin
            pos <= (pos == LAST) ? '0 : pos + 1'b1;
        end
    end

    // Notch flag reflects the current (pre-step) position.
    assign at_notch = (pos == NOTCH_POS);

endmodule

// File: rtl/rotor_step_controller.sv
// Rotor stepping controller: on a key press steps the three rotors with the
// classic double-step rule, hands the letter to the substitution datapath,
// waits for its acknowledge and presents the ciphertext for one cycle.
// In IDLE with configuration mode held, rotors can be advanced one at a time.
module rotor_step_controller
    import enigma_pkg::*;
#(
    parameter int NOTCH_R = NOTCH_R_DEFAULT,
    parameter int NOTCH_M = NOTCH_M_DEFAULT,
    parameter int ALPHA   = enigma_pkg::ALPHA
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [4:0]    key_code,
    input  logic          cfg_enable,
    input  logic [1:0]    cfg_select,
    input  logic          cfg_increment,
    input  logic          cipher_ack,
    input  logic [4:0]    cipher_result,
    output logic [4:0]    pos_r,
    output logic [4:0]    pos_m,
    output logic [4:0]    pos_l,
    output logic          cipher_req,
    output logic [4:0]    cipher_key,
    output logic          out_valid,
    output logic [4:0]    out_char,
    output logic          busy
);

    localparam letter_t LAST = last_letter(ALPHA);

    state_t state;

    logic notch_r;
    logic notch_m;
    logic key_accept;
    logic cfg_go;
    logic step;
    logic inc_r;
    logic inc_m;
    logic inc_l;

    // A key only starts a cycle from IDLE, outside configuration mode and
    // with a legal letter; configuration wins whenever cfg_enable is held.
    assign key_accept = (state == ST_IDLE) && key_valid && !cfg_enable
                        && (key_code <= LAST);
    assign cfg_go     = (state == ST_IDLE) && cfg_enable && cfg_increment;
    assign step       = (state == ST_STEP);

    // Rotor advance enables: key stepping with double-step, or a manual
    // single-rotor nudge that never carries into a neighbour.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which keeps this purely combinational with no latch.
    always_comb begin
        inc_r = 1'b0;
        inc_m = 1'b0;
        inc_l = 1'b0;
        if (step) begin
            inc_r = 1'b1;
            inc_m = notch_r || notch_m;
            inc_l = notch_m;
        end else if (cfg_go) begin
            case (cfg_select)
                2'd0:    inc_r = 1'b1;
                2'd1:    inc_m = 1'b1;
                2'd2:    inc_l = 1'b1;
                default: ;
            endcase
        end
    end

    rotor_counter #(.ALPHA(ALPHA), .NOTCH(NOTCH_R)) u_rotor_r (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc_r),
        .pos      (pos_r),
        .at_notch (notch_r)
    );

    rotor_counter #(.ALPHA(ALPHA), .NOTCH(NOTCH_M)) u_rotor_m (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc_m),
        .pos      (pos_m),
        .at_notch (notch_m)
    );

    // Left rotor turnover is never used as a step condition.
    rotor_counter #(.ALPHA(ALPHA), .NOTCH(0)) u_rotor_l (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc_l),
        .pos      (pos_l),
        .at_notch ()
    );

    // Controller FSM with registered handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cipher_req <= 1'b0;
            cipher_key <= '0;
            out_valid  <= 1'b0;
            out_char   <= '0;
            busy       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_accept) begin
                        cipher_key <= key_code;
                        busy       <= 1'b1;
                        state      <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    cipher_req <= 1'b1;
                    state      <= ST_REQ;
                end
                ST_REQ: begin
                    if (cipher_ack) begin
                        cipher_req <= 1'b0;
                        out_char   <= cipher_result;
                        out_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    cipher_req <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_step_controller.sv
// Directed bench for rotor_step_controller: expected ciphertext is queued at
// each key press and matched against every out_valid pulse seen.
module tb_rotor_step_controller;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [4:0] key_code;
    logic       cfg_enable;
    logic [1:0] cfg_select;
    logic       cfg_increment;
    logic       cipher_ack;
    logic [4:0] cipher_result;
    logic [4:0] pos_r;
    logic [4:0] pos_m;
    logic [4:0] pos_l;
    logic       cipher_req;
    logic [4:0] cipher_key;
    logic       out_valid;
    logic [4:0] out_char;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    rotor_step_controller dut (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .cfg_enable    (cfg_enable),
        .cfg_select    (cfg_select),
        .cfg_increment (cfg_increment),
        .cipher_ack    (cipher_ack),
        .cipher_result (cipher_result),
        .pos_r         (pos_r),
        .pos_m         (pos_m),
        .pos_l         (pos_l),
        .cipher_req    (cipher_req),
        .cipher_key    (cipher_key),
        .out_valid     (out_valid),
        .out_char      (out_char),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every ciphertext pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (out_valid === 1'b1) obs_q.push_back(out_char);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int l, input int m, input int r);
        check({tag, "_l"}, 32'(pos_l), 32'(l));
        check({tag, "_m"}, 32'(pos_m), 32'(m));
        check({tag, "_r"}, 32'(pos_r), 32'(r));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_inc(input logic [1:0] sel, input int n);
        cfg_enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            cfg_select    = sel;
            cfg_increment = 1'b1;
            tick();
            cfg_increment = 1'b0;
            tick();
        end
        cfg_enable = 1'b0;
        tick();
    endtask

    // Match every observed ciphertext against the queued expectations.
    task automatic scoreboard(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        check({tag, "_sb_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_sb_char"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // One key press with ack after ack_delay REQ cycles; optionally fires a
    // second key and a config nudge while the request is outstanding.
    task automatic press(input string tag, input logic [4:0] key, input logic [4:0] result,
                         input int ack_delay, input bit disturb, output int req_cycles);
        exp_q.push_back(result);
        key_valid = 1'b1;
        key_code  = key;
        tick();
        key_valid  = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 8 && cipher_req !== 1'b1; i++) tick();
        check({tag, "_req_seen"}, 32'(cipher_req), 32'd1);
        check({tag, "_cipher_key"}, 32'(cipher_key), 32'(key));
        if (cipher_req === 1'b1) req_cycles = 1;
        for (int i = 0; i < ack_delay; i++) begin
            if (disturb && i == 0) begin
                key_valid = 1'b1;
                key_code  = 5'd20;
            end
            if (disturb && i == 1) begin
                cfg_enable    = 1'b1;
                cfg_select    = 2'd0;
                cfg_increment = 1'b1;
            end
            tick();
            key_valid     = 1'b0;
            cfg_increment = 1'b0;
            if (cipher_req === 1'b1) req_cycles++;
        end
        cipher_ack    = 1'b1;
        cipher_result = result;
        tick();
        cipher_ack = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_char"}, 32'(out_char), 32'(result));
        tick();
        cfg_enable = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        scoreboard(tag);
    endtask

    initial begin
        int rc;
        reset         = 1'b1;
        key_valid     = 1'b0;
        key_code      = '0;
        cfg_enable    = 1'b0;
        cfg_select    = '0;
        cfg_increment = 1'b0;
        cipher_ack    = 1'b0;
        cipher_result = '0;
        tick();
        tick();

        // Reset state.
        check_pos("rst", 0, 0, 0);
        check("rst_req", 32'(cipher_req), 32'd0);
        check("rst_key", 32'(cipher_key), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_char", 32'(out_char), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Key 0, ack in first REQ cycle, result 7: out_valid 3 cycles later.
        exp_q.push_back(5'd7);
        key_valid = 1'b1;
        key_code  = 5'd0;
        tick();
        key_valid = 1'b0;
        check("lat_c1_busy", 32'(busy), 32'd1);
        check("lat_c1_req", 32'(cipher_req), 32'd0);
        tick();
        check("lat_c2_req", 32'(cipher_req), 32'd1);
        check("lat_c2_key", 32'(cipher_key), 32'd0);
        check_pos("lat_c2", 0, 0, 1);
        check("lat_c2_valid", 32'(out_valid), 32'd0);
        cipher_ack    = 1'b1;
        cipher_result = 5'd7;
        tick();
        cipher_ack = 1'b0;
        check("lat_c3_valid", 32'(out_valid), 32'd1);
        check("lat_c3_char", 32'(out_char), 32'd7);
        check("lat_c3_req", 32'(cipher_req), 32'd0);
        tick();
        check("lat_c4_valid", 32'(out_valid), 32'd0);
        check("lat_c4_busy", 32'(busy), 32'd0);
        scoreboard("lat");

        // Right-rotor notch carries into the middle rotor.
        do_reset();
        cfg_inc(2'd0, 21);
        check_pos("notch_pre", 0, 0, 21);
        press("notch", 5'd5, 5'd12, 0, 1'b0, rc);
        check_pos("notch_post", 0, 1, 22);

        // Right-rotor wrap 25 -> 0 without a middle step.
        do_reset();
        cfg_inc(2'd0, 25);
        press("wrap", 5'd25, 5'd3, 1, 1'b0, rc);
        check_pos("wrap_post", 0, 0, 0);

        // Double step: middle rotor advances again and drags the left one.
        do_reset();
        cfg_inc(2'd1, 3);
        cfg_inc(2'd0, 21);
        press("dbl1", 5'd10, 5'd1, 0, 1'b0, rc);
        check_pos("dbl1_post", 0, 4, 22);
        press("dbl2", 5'd11, 5'd2, 2, 1'b0, rc);
        check_pos("dbl2_post", 1, 5, 23);

        // Config: 27 increments of the left rotor wrap to 1, no carries.
        do_reset();
        cfg_inc(2'd2, 27);
        check_pos("cfg_l", 1, 0, 0);
        cfg_enable = 1'b1;
        key_valid  = 1'b1;
        key_code   = 5'd4;
        tick();
        key_valid = 1'b0;
        check("cfgkey_busy", 32'(busy), 32'd0);
        tick();
        check("cfgkey_req", 32'(cipher_req), 32'd0);
        check_pos("cfgkey", 1, 0, 0);
        // Simultaneous key and increment: config applied, key dropped.
        cfg_select    = 2'd0;
        cfg_increment = 1'b1;
        key_valid     = 1'b1;
        tick();
        cfg_increment = 1'b0;
        key_valid     = 1'b0;
        tick();
        check("simul_busy", 32'(busy), 32'd0);
        check("simul_req", 32'(cipher_req), 32'd0);
        check_pos("simul", 1, 0, 1);
        // Select 3 is a no-op.
        cfg_select    = 2'd3;
        cfg_increment = 1'b1;
        tick();
        cfg_increment = 1'b0;
        tick();
        check_pos("sel3", 1, 0, 1);
        // Increment without configuration mode is ignored.
        cfg_enable    = 1'b0;
        cfg_select    = 2'd1;
        cfg_increment = 1'b1;
        tick();
        cfg_increment = 1'b0;
        tick();
        check_pos("nocfg", 1, 0, 1);
        // Out-of-range key code is ignored.
        key_valid = 1'b1;
        key_code  = 5'd26;
        tick();
        key_valid = 1'b0;
        tick();
        check("badkey_busy", 32'(busy), 32'd0);
        check_pos("badkey", 1, 0, 1);
        scoreboard("cfg");

        // Ack delayed 5 cycles with a second key and a config nudge in REQ.
        do_reset();
        press("delay", 5'd3, 5'd9, 5, 1'b1, rc);
        check("delay_req_cycles", 32'(rc), 32'd6);
        check_pos("delay_post", 0, 0, 1);

        // Reset mid-handshake aborts; a late ack is ignored.
        do_reset();
        key_valid = 1'b1;
        key_code  = 5'd2;
        tick();
        key_valid = 1'b0;
        tick();
        check("abort_req_before", 32'(cipher_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_req", 32'(cipher_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check_pos("abort", 0, 0, 0);
        cipher_ack    = 1'b1;
        cipher_result = 5'd11;
        tick();
        cipher_ack = 1'b0;
        tick();
        tick();
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy_late", 32'(busy), 32'd0);
        check("abort_no_output", 32'(obs_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
